reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 28 ++
 rtl/reorder_buffer_if.sv | 57 +++++
 rtl/reorder_buffer_rob_lookup.sv | 64 ++++++
 rtl/reorder_buffer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared widths, the reserved free tag and the entry layout for the reorder buffer.
// Tags with the MSB set (tagFree and above) never name an entry.
package reorder_buffer_pkg;

  localparam int tagWidth    = 4;
  localparam int robDepth    = 8;
  localparam int robIdxWidth = 3;
  localparam int regWidth    = 5;
  localparam int dataWidth   = 32;

  localparam logic [tagWidth-1:0] tagFree = 4'b1000;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [regWidth-1:0]  rd;
    logic [dataWidth-1:0] data;
  } rob_entry_t;

  function automatic logic tag_is_entry(input logic [tagWidth-1:0] tag);
    return (tag & tagFree) == '0;
  endfunction

  function automatic logic [robIdxWidth-1:0] tag_idx(input logic [tagWidth-1:0] tag);
    return tag[robIdxWidth-1:0];
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Decoder/CDB/commit bundle of the reorder buffer; master is the pipeline side, slave the ROB.
// Handshake: no back-pressure; alloc_en is accepted only while rob_full is low, CDB ports are fire-and-forget.
interface reorder_buffer_if;
  import reorder_buffer_pkg::*;

  logic                   alloc_en;
  logic [regWidth-1:0]    alloc_rd;
  logic [robIdxWidth-1:0] rob_tail;
  logic                   rob_full;

  logic [tagWidth-1:0]    tag_check1;
  logic [tagWidth-1:0]    tag_check2;
  logic [tagWidth-1:0]    tag_checkd;
  logic                   tag1_ready;
  logic                   tag2_ready;
  logic                   tagd_ready;
  logic [dataWidth-1:0]   rob_data1;
  logic [dataWidth-1:0]   rob_data2;
  logic [dataWidth-1:0]   rob_datad;

  logic                   cdb_alu_valid;
  logic [tagWidth-1:0]    cdb_alu_tag;
  logic [dataWidth-1:0]   cdb_alu_data;
  logic                   cdb_ls_valid;
  logic [tagWidth-1:0]    cdb_ls_tag;
  logic [dataWidth-1:0]   cdb_ls_data;

  logic                   commit_en;
  logic [regWidth-1:0]    commit_rd;
  logic [dataWidth-1:0]   commit_data;
  logic [tagWidth-1:0]    commit_tag;

  logic                   flush;

  // Occupancy state exposed for observation.
  logic [robIdxWidth-1:0] rob_head;
  logic [robIdxWidth:0]   rob_count;

  modport master (
    output alloc_en, alloc_rd, tag_check1, tag_check2, tag_checkd,
           cdb_alu_valid, cdb_alu_tag, cdb_alu_data,
           cdb_ls_valid, cdb_ls_tag, cdb_ls_data, flush,
    input  rob_tail, rob_full, tag1_ready, tag2_ready, tagd_ready,
           rob_data1, rob_data2, rob_datad,
           commit_en, commit_rd, commit_data, commit_tag, rob_head, rob_count
  );

  modport slave (
    input  alloc_en, alloc_rd, tag_check1, tag_check2, tag_checkd,
           cdb_alu_valid, cdb_alu_tag, cdb_alu_data,
           cdb_ls_valid, cdb_ls_tag, cdb_ls_data, flush,
    output rob_tail, rob_full, tag1_ready, tag2_ready, tagd_ready,
           rob_data1, rob_data2, rob_datad,
           commit_en, commit_rd, commit_data, commit_tag, rob_head, rob_count
  );

endinterface

// File: rtl/reorder_buffer_rob_lookup.sv
// Operand lookup: tag -> ready/data from stored entries.
// With ROB_CDB_BYPASS_EN defined, same-cycle CDB broadcasts are matched first (ALU over LS).
module rob_lookup
  import reorder_buffer_pkg::*;
(
  input  logic                               enable,
  input  logic [tagWidth-1:0]                tag_check,
  input  logic [robDepth-1:0]                busy,
  input  logic [robDepth-1:0]                done,
  input  logic [robDepth-1:0][dataWidth-1:0] data,
  input  logic                               alu_valid,
  input  logic [tagWidth-1:0]                alu_tag,
  input  logic [dataWidth-1:0]               alu_data,
  input  logic                               ls_valid,
  input  logic [tagWidth-1:0]                ls_tag,
  input  logic [dataWidth-1:0]               ls_data,
  output logic                               ready,
  output logic [dataWidth-1:0]               result
);

  logic [robIdxWidth-1:0] idx;
  logic                   stored_hit;

  assign idx        = tag_idx(tag_check);
  assign stored_hit = tag_is_entry(tag_check) && busy[idx] && done[idx];

`ifdef ROB_CDB_BYPASS_EN
  logic alu_hit;
  logic ls_hit;

  assign alu_hit = alu_valid && (alu_tag == tag_check) && tag_is_entry(tag_check);
  assign ls_hit  = ls_valid && (ls_tag == tag_check) && tag_is_entry(tag_check);

  always_comb begin
    ready  = 1'b0;
    result = '0;
    if (enable) begin
      if (alu_hit) begin
        ready  = 1'b1;
        result = alu_data;
      end else if (ls_hit) begin
        ready  = 1'b1;
        result = ls_data;
      end else if (stored_hit) begin
        ready  = 1'b1;
        result = data[idx];
      end
    end
  end
`else
  logic unused_cdb;
  assign unused_cdb = ^{alu_valid, alu_tag, alu_data, ls_valid, ls_tag, ls_data};

  always_comb begin
    ready  = 1'b0;
    result = '0;
    if (enable && stored_hit) begin
      ready  = 1'b1;
      result = data[idx];
    end
  end
`endif

endmodule

// File: rtl/reorder_buffer.sv
// 8-entry in-order reorder buffer: allocation at tail, CDB completion, in-order commit at head.
// Optional ROB_CDB_BYPASS_EN lets operand lookups see same-cycle CDB broadcasts.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  reorder_buffer_if.slave rob
);

  rob_entry_t entries [robDepth];

  logic [robIdxWidth-1:0] head;
  logic [robIdxWidth-1:0] tail;
  logic [robIdxWidth:0]   count;

  logic                   full;
  logic                   alloc_ok;
  logic                   commit_ok;
  logic                   clear;
  logic [robIdxWidth-1:0] alu_idx;
  logic [robIdxWidth-1:0] ls_idx;
  logic                   alu_wr;
  logic                   ls_wr;

  logic [robDepth-1:0]                busy_v;
  logic [robDepth-1:0]                done_v;
  logic [robDepth-1:0][dataWidth-1:0] data_v;

  assign clear    = rst || rob.flush;
  // Full is taken from the registered count, so a same-cycle commit frees no slot.
  assign full     = (count == (robIdxWidth+1)'(robDepth));
  assign alloc_ok = rob.alloc_en && !full;

  assign alu_idx = tag_idx(rob.cdb_alu_tag);
  assign ls_idx  = tag_idx(rob.cdb_ls_tag);
  assign alu_wr  = rob.cdb_alu_valid && tag_is_entry(rob.cdb_alu_tag)
                   && entries[alu_idx].busy && !entries[alu_idx].done;
  assign ls_wr   = rob.cdb_ls_valid && tag_is_entry(rob.cdb_ls_tag)
                   && entries[ls_idx].busy && !entries[ls_idx].done
                   && !(alu_wr && (alu_idx == ls_idx));

  assign commit_ok = entries[head].busy && entries[head].done && !clear;

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < robDepth; i++) begin
        entries[i].busy <= 1'b0;
        entries[i].done <= 1'b0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_ok) begin
        entries[tail].busy <= 1'b1;
        entries[tail].done <= 1'b0;
        entries[tail].rd   <= rob.alloc_rd;
        tail               <= tail + 1'b1;
      end
      if (alu_wr) begin
        entries[alu_idx].done <= 1'b1;
        entries[alu_idx].data <= rob.cdb_alu_data;
      end
      if (ls_wr) begin
        entries[ls_idx].done <= 1'b1;
        entries[ls_idx].data <= rob.cdb_ls_data;
      end
      if (commit_ok) begin
        entries[head].busy <= 1'b0;
        head               <= head + 1'b1;
      end
      case ({alloc_ok, commit_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < robDepth; i++) begin
      busy_v[i] = entries[i].busy;
      done_v[i] = entries[i].done;
      data_v[i] = entries[i].data;
    end
  end

  rob_lookup u_lookup1 (
    .enable(!rst), .tag_check(rob.tag_check1),
    .busy(busy_v), .done(done_v), .data(data_v),
    .alu_valid(rob.cdb_alu_valid), .alu_tag(rob.cdb_alu_tag), .alu_data(rob.cdb_alu_data),
    .ls_valid(rob.cdb_ls_valid), .ls_tag(rob.cdb_ls_tag), .ls_data(rob.cdb_ls_data),
    .ready(rob.tag1_ready), .result(rob.rob_data1)
  );

  rob_lookup u_lookup2 (
    .enable(!rst), .tag_check(rob.tag_check2),
    .busy(busy_v), .done(done_v), .data(data_v),
    .alu_valid(rob.cdb_alu_valid), .alu_tag(rob.cdb_alu_tag), .alu_data(rob.cdb_alu_data),
    .ls_valid(rob.cdb_ls_valid), .ls_tag(rob.cdb_ls_tag), .ls_data(rob.cdb_ls_data),
    .ready(rob.tag2_ready), .result(rob.rob_data2)
  );

  rob_lookup u_lookupd (
    .enable(!rst), .tag_check(rob.tag_checkd),
    .busy(busy_v), .done(done_v), .data(data_v),
    .alu_valid(rob.cdb_alu_valid), .alu_tag(rob.cdb_alu_tag), .alu_data(rob.cdb_alu_data),
    .ls_valid(rob.cdb_ls_valid), .ls_tag(rob.cdb_ls_tag), .ls_data(rob.cdb_ls_data),
    .ready(rob.tagd_ready), .result(rob.rob_datad)
  );

  // Everything reads as zero while rst is asserted, even before the first clearing edge.
  assign rob.rob_tail    = rst ? '0 : tail;
  assign rob.rob_full    = !rst && full;
  assign rob.commit_en   = commit_ok;
  assign rob.commit_rd   = commit_ok ? entries[head].rd : '0;
  assign rob.commit_data = commit_ok ? entries[head].data : '0;
  assign rob.commit_tag  = rst ? '0 : {1'b0, head};
  assign rob.rob_head    = rst ? '0 : head;
  assign rob.rob_count   = rst ? '0 : count;

endmodule
